dnn_result_collector: RTL

Output-side stage that sits directly downstream of the DNN core and consumes its two output-neuron results (`out0`, `out1`) and their ready strobes. For each sample, it computes the winning class and the decision margin, and buffers the results in a small FIFO that a consumer drains through a valid/ready handshake. It also optionally forms a majority vote over a fixed frame of samples. Drops caused by a full FIFO and protocol errors are flagged as sticky status.

---
 rtl/dnn_result_collector.sv | 117 +++++++++++
 1 files changed

// File: rtl/dnn_result_collector.sv
// rtl/dnn_result_collector.sv - per-sample class/margin FIFO with sticky drop/protocol status
// Optional frame majority vote is built when DNN_COLLECT_FRAME_EN is defined.
module dnn_result_collector #(
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 8,
  localparam int VW       = $clog2(FRAME_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [20:0] out0,
  input  logic signed [20:0] out1,
  input  logic               out0_ready,
  input  logic               out1_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_class,
  output logic [21:0]        res_margin,
  output logic               overflow,
  output logic [7:0]         drop_cnt,
  output logic               proto_err,
  output logic               frame_valid,
  output logic               frame_class,
  output logic [VW-1:0]      frame_votes1
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr, rd_ptr;
  logic [22:0]        mem [DEPTH];
  logic [22:0]        head;
  logic signed [21:0] diff;
  logic               s_class;
  logic [21:0]        s_margin;
  logic               accept, empty, full, pop, push, drop;

  always_comb begin
    diff     = {out0[20], out0} - {out1[20], out1};
    s_class  = diff[21];
    s_margin = diff[21] ? 22'(-diff) : 22'(diff);
  end

  assign accept = out0_ready & out1_ready;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = !empty && res_ready;
  // A full FIFO still takes the sample when the head leaves in the same cycle.
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  assign head       = mem[rd_ptr[AW-1:0]];
  assign res_valid  = !empty;
  assign res_class  = res_valid & head[22];
  assign res_margin = res_valid ? head[21:0] : 22'd0;

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr[AW-1:0]] <= {s_class, s_margin};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= 8'd0;
      proto_err <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end
      if (out0_ready != out1_ready)
        proto_err <= 1'b1;
    end
  end

`ifdef DNN_COLLECT_FRAME_EN
  logic [VW-1:0] smp_cnt, vote_cnt, votes_now;

  assign votes_now = vote_cnt + VW'(s_class);

  // Counters follow accepted samples, whether or not the FIFO kept them.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_cnt      <= '0;
      vote_cnt     <= '0;
      frame_valid  <= 1'b0;
      frame_class  <= 1'b0;
      frame_votes1 <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (accept) begin
        if (smp_cnt == VW'(FRAME_LEN - 1)) begin
          frame_votes1 <= votes_now;
          frame_class  <= ({votes_now, 1'b0} > (VW + 1)'(FRAME_LEN));
          frame_valid  <= 1'b1;
          smp_cnt      <= '0;
          vote_cnt     <= '0;
        end else begin
          smp_cnt  <= smp_cnt + 1'b1;
          vote_cnt <= votes_now;
        end
      end
    end
  end
`else
  assign frame_valid  = 1'b0;
  assign frame_class  = 1'b0;
  assign frame_votes1 = '0;
`endif

endmodule
